imem_fetch_ctrl: RTL and testbench

- Parametrised, word-organised instruction memory with a fetch request/response handshake and a program-load port.
- Sits between the PC/fetch stage and the decode stage.
- Contents are written by a loader before execution, not hard-coded at reset.
- Reports misaligned, out-of-range and (optionally) parity faults alongside each returned instruction.

---
 rtl/imem_pkg.sv | 22 ++
 rtl/imem_fetch_ctrl_if.sv | 28 ++
 rtl/imem_array.sv | 27 ++
 rtl/imem_fetch_ctrl.sv | 122 ++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction memory fetch controller.
package imem_pkg;
   localparam int INSTR_W = 32;

   typedef enum logic [1:0] {
      FLT_NONE     = 2'd0,
      FLT_MISALIGN = 2'd1,
      FLT_RANGE    = 2'd2,
      FLT_PARITY   = 2'd3
   } fault_e;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_LOAD  = 2'd2
   } state_e;

   // Even parity: the stored bit makes the total number of ones even.
   function automatic logic word_parity(input logic [INSTR_W-1:0] w);
      return ^w;
   endfunction
endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Load, fetch-request and fetch-response signals of the instruction memory.
interface imem_fetch_ctrl_if;
   logic        load_mode;
   logic        ld_valid;
   logic        ld_ready;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;
   logic        ld_err;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_pc;
   logic        flush;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_instr;
   logic [1:0]  rsp_fault;
   logic        busy_load;

   modport master (
      output load_mode, ld_valid, ld_addr, ld_data, req_valid, req_pc, flush, rsp_ready,
      input  ld_ready, ld_err, req_ready, rsp_valid, rsp_instr, rsp_fault, busy_load
   );

   modport slave (
      input  load_mode, ld_valid, ld_addr, ld_data, req_valid, req_pc, flush, rsp_ready,
      output ld_ready, ld_err, req_ready, rsp_valid, rsp_instr, rsp_fault, busy_load
   );
endinterface

// File: rtl/imem_array.sv
// Word storage with one write port and one registered read port; contents are never reset.
module imem_array
   import imem_pkg::*;
#(
   parameter  int DEPTH_WORDS = 256,
   parameter  int WORD_W      = INSTR_W,
   localparam int ADDR_W      = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WORD_W-1:0] rdata
);
   logic [WORD_W-1:0] mem [DEPTH_WORDS];
   logic [WORD_W-1:0] rdata_q;

   // Read data only changes on an accepted fetch, so a stalled response stays stable.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata_q <= mem[raddr];
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction memory with fetch handshake, program-load port and fault reporting.
// Optional per-word even parity is enabled by defining IMEM_PARITY_EN.
module imem_fetch_ctrl
   import imem_pkg::*;
#(
   parameter  int          DEPTH_WORDS = 256,
   parameter  logic [31:0] BASE_ADDR   = 32'h0000_0000,
   localparam int          ADDR_W      = $clog2(DEPTH_WORDS)
) (
   input logic               clk,
   input logic               reset,
   imem_fetch_ctrl_if.slave  bus
);
`ifdef IMEM_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif
   localparam int WORD_W = INSTR_W + PAR_W;

   state_e state_q, state_d;
   logic   rsp_valid_q, rsp_valid_d;
   fault_e rsp_fault_q, rsp_fault_d;
   logic   ld_err_q, ld_err_d;

   logic [31:0]       req_off, ld_off;
   fault_e            req_flt, ld_flt, rsp_fault;
   logic              req_fire, ld_fire, parity_bad, word_ok;
   logic [WORD_W-1:0] wdata, rdata;

   // Misalignment is taken from the offset; BASE_ADDR is word aligned so the low bits match.
   function automatic fault_e addr_fault(input logic [31:0] a, input logic [31:0] off);
      if (off[1:0] != 2'b00) return FLT_MISALIGN;
      if (a < BASE_ADDR || off[31:2] >= 30'(DEPTH_WORDS)) return FLT_RANGE;
      return FLT_NONE;
   endfunction

   assign req_off = bus.req_pc - BASE_ADDR;
   assign ld_off  = bus.ld_addr - BASE_ADDR;
   assign req_flt = addr_fault(bus.req_pc, req_off);
   assign ld_flt  = addr_fault(bus.ld_addr, ld_off);

   assign bus.req_ready = (state_q == ST_RUN) & ~bus.load_mode & ~bus.flush &
                          (~rsp_valid_q | bus.rsp_ready);
   assign bus.ld_ready  = (state_q == ST_LOAD);
   assign req_fire      = bus.req_valid & bus.req_ready;
   assign ld_fire       = bus.ld_valid & bus.ld_ready;

   always_comb begin
      state_d     = state_q;
      rsp_valid_d = rsp_valid_q;
      rsp_fault_d = rsp_fault_q;
      ld_err_d    = ld_fire & (ld_flt != FLT_NONE);
      if (bus.flush) begin
         rsp_valid_d = 1'b0;
      end else if (req_fire) begin
         rsp_valid_d = 1'b1;
         rsp_fault_d = req_flt;
      end else if (bus.rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
      // DRAIN leaves for LOAD on the same edge the last response goes away.
      case (state_q)
         ST_RUN:   if (bus.load_mode) state_d = rsp_valid_q ? ST_DRAIN : ST_LOAD;
         ST_DRAIN: if (!bus.load_mode) state_d = ST_RUN;
                   else if (!rsp_valid_d) state_d = ST_LOAD;
         ST_LOAD:  if (!bus.load_mode) state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_RUN;
         rsp_valid_q <= 1'b0;
         rsp_fault_q <= FLT_NONE;
         ld_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_fault_q <= rsp_fault_d;
         ld_err_q    <= ld_err_d;
      end
   end

`ifdef IMEM_PARITY_EN
   assign wdata      = {word_parity(bus.ld_data), bus.ld_data};
   assign parity_bad = ^rdata;
`else
   assign wdata      = bus.ld_data;
   assign parity_bad = 1'b0;
`endif

   imem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .WORD_W      (WORD_W)
   ) u_array (
      .clk   (clk),
      .we    (ld_fire & (ld_flt == FLT_NONE)),
      .waddr (ld_off[ADDR_W+1:2]),
      .wdata (wdata),
      .re    (req_fire),
      .raddr (req_off[ADDR_W+1:2]),
      .rdata (rdata)
   );

   // Address faults outrank parity; outputs are gated by valid so reset forces zeros.
   always_comb begin
      rsp_fault = FLT_NONE;
      if (rsp_valid_q) begin
         if (rsp_fault_q != FLT_NONE) rsp_fault = rsp_fault_q;
         else if (parity_bad)         rsp_fault = FLT_PARITY;
      end
   end

   assign word_ok       = rsp_valid_q & (rsp_fault == FLT_NONE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_fault = rsp_fault;
   assign bus.rsp_instr = word_ok ? rdata[INSTR_W-1:0] : 32'h0;
   assign bus.ld_err    = ld_err_q;
   assign bus.busy_load = (state_q == ST_LOAD);
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: accepted fetches push expectations, a monitor pops them.
module tb_imem_fetch_ctrl;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   typedef struct packed {
      logic [31:0] instr;
      logic [1:0]  flt;
      logic        lat;
      int          acc_cyc;
   } exp_t;
   exp_t sb[$];

   imem_fetch_ctrl_if bus();

   imem_fetch_ctrl #(
      .DEPTH_WORDS (256),
      .BASE_ADDR   (32'h0000_0000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: responses delivered (valid & ready, not flushed) are matched in order.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && bus.rsp_valid && bus.rsp_ready && !bus.flush) begin
            if (sb.size() == 0) begin
               chk("unexpected_rsp", bus.rsp_instr, 32'hxxxx_xxxx);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("rsp_instr", bus.rsp_instr, e.instr);
               chk("rsp_fault", 32'(bus.rsp_fault), 32'(e.flt));
               if (e.lat) chk("latency", 32'(cyc - e.acc_cyc), 32'd1);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic issue(input logic [31:0] pc, input logic [31:0] ei, input logic [1:0] ef,
                        input logic lat, input logic push, output int waited);
      exp_t e;
      bus.req_valid = 1'b1;
      bus.req_pc    = pc;
      waited        = 0;
      @(negedge clk);
      while (!bus.req_ready && waited < 20) begin
         waited++;
         @(negedge clk);
      end
      chk("req_accept", 32'(bus.req_ready), 32'd1);
      if (bus.req_ready && push) begin
         e.instr = ei; e.flt = ef; e.lat = lat; e.acc_cyc = cyc;
         sb.push_back(e);
      end
      @(posedge clk); #1;
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] d, input logic exp_err);
      bus.ld_valid = 1'b1;
      bus.ld_addr  = a;
      bus.ld_data  = d;
      @(negedge clk);
      chk("ld_ready", 32'(bus.ld_ready), 32'd1);
      @(posedge clk); #1;
      bus.ld_valid = 1'b0;
      @(negedge clk);
      chk("ld_err", 32'(bus.ld_err), 32'(exp_err));
      @(posedge clk); #1;
      if (exp_err) begin
         @(negedge clk);
         chk("ld_err_pulse_end", 32'(bus.ld_err), 32'd0);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int w;
      reset         = 1'b1;
      bus.load_mode = 1'b0; bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
      bus.req_valid = 1'b0; bus.req_pc   = '0;   bus.flush   = 1'b0; bus.rsp_ready = 1'b0;
      @(negedge clk);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_instr", bus.rsp_instr, 32'd0);
      chk("rst_rsp_fault", 32'(bus.rsp_fault), 32'd0);
      chk("rst_ld_err", 32'(bus.ld_err), 32'd0);
      chk("rst_busy", 32'(bus.busy_load), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Program download, including two rejected addresses that alias word 0
      bus.load_mode = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("busy_in_load", 32'(bus.busy_load), 32'd1);
      @(posedge clk); #1;
      load(32'h0, 32'h0094_0333, 1'b0);
      load(32'h4, 32'h4139_03b3, 1'b0);
      load(32'h8, 32'h00a0_0093, 1'b0);
      load(32'hC, 32'h1234_5678, 1'b0);
      load(32'h401, 32'hdead_beef, 1'b1);
      load(32'h2, 32'hcafe_f00d, 1'b1);
      bus.load_mode = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("busy_after_load", 32'(bus.busy_load), 32'd0);
      chk("req_ready_run", 32'(bus.req_ready), 32'd1);
      @(posedge clk); #1;

      // Back-to-back fetches
      bus.rsp_ready = 1'b1;
      issue(32'h0, 32'h0094_0333, 2'd0, 1'b1, 1'b1, w);
      issue(32'h4, 32'h4139_03b3, 2'd0, 1'b1, 1'b1, w);
      issue(32'h8, 32'h00a0_0093, 2'd0, 1'b1, 1'b1, w);
      bus.req_valid = 1'b0;
      @(posedge clk); #1;

      // Stalled response is held; next request accepted on release
      bus.rsp_ready = 1'b0;
      issue(32'h4, 32'h4139_03b3, 2'd0, 1'b0, 1'b1, w);
      bus.req_pc = 32'h0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
         chk("stall_instr", bus.rsp_instr, 32'h4139_03b3);
         chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
         @(posedge clk); #1;
      end
      bus.rsp_ready = 1'b1;
      issue(32'h0, 32'h0094_0333, 2'd0, 1'b1, 1'b1, w);
      chk("release_accept_wait", 32'(w), 32'd0);

      // Address faults, misaligned outranks range
      issue(32'h2, 32'h0, 2'd1, 1'b1, 1'b1, w);
      issue(32'h400, 32'h0, 2'd2, 1'b1, 1'b1, w);
      issue(32'hFFFF_FFFC, 32'h0, 2'd2, 1'b1, 1'b1, w);
      issue(32'h403, 32'h0, 2'd1, 1'b1, 1'b1, w);
      bus.req_valid = 1'b0;
      @(posedge clk); #1;

      // Flush of a stalled response
      bus.rsp_ready = 1'b0;
      issue(32'h8, 32'h0, 2'd0, 1'b0, 1'b0, w);
      bus.flush  = 1'b1;
      bus.req_pc = 32'h0;
      @(negedge clk);
      chk("flush_req_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
      bus.flush = 1'b0; bus.req_valid = 1'b0;
      @(negedge clk);
      chk("flush_cleared", 32'(bus.rsp_valid), 32'd0);
      @(posedge clk); #1;

      // Flush together with rsp_ready drops the response
      bus.rsp_ready = 1'b1;
      issue(32'h8, 32'h0, 2'd0, 1'b0, 1'b0, w);
      bus.req_valid = 1'b0; bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      @(negedge clk);
      chk("flush_ready_cleared", 32'(bus.rsp_valid), 32'd0);
      @(posedge clk); #1;

      // Load request while a response is stalled goes through DRAIN
      bus.rsp_ready = 1'b0;
      issue(32'hC, 32'h1234_5678, 2'd0, 1'b0, 1'b1, w);
      bus.req_valid = 1'b0; bus.load_mode = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("drain_ld_ready", 32'(bus.ld_ready), 32'd0);
         chk("drain_busy", 32'(bus.busy_load), 32'd0);
         @(posedge clk); #1;
      end
      bus.rsp_ready = 1'b1;
      w = 0;
      @(negedge clk);
      while (!bus.ld_ready && w < 10) begin
         w++;
         @(negedge clk);
      end
      chk("drain_to_load", 32'(bus.ld_ready), 32'd1);
      chk("drain_wait", 32'(w), 32'd1);
      chk("load_busy", 32'(bus.busy_load), 32'd1);
      @(posedge clk); #1;

      // Reset in the middle of LOAD with an ld_err pulse outstanding
      bus.ld_valid = 1'b1; bus.ld_addr = 32'h401;
      @(posedge clk); #1;
      bus.ld_valid = 1'b0;
      chk("pre_rst_ld_err", 32'(bus.ld_err), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("rst_load_ld_err", 32'(bus.ld_err), 32'd0);
      chk("rst_load_busy", 32'(bus.busy_load), 32'd0);
      chk("rst_load_ld_ready", 32'(bus.ld_ready), 32'd0);
      bus.load_mode = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;

      // Reset in the middle of a pending fetch response
      bus.rsp_ready = 1'b0;
      issue(32'h0, 32'h0, 2'd0, 1'b0, 1'b0, w);
      bus.req_valid = 1'b0;
      chk("pre_rst_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("rst_fetch_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_fetch_instr", bus.rsp_instr, 32'd0);
      chk("rst_fetch_fault", 32'(bus.rsp_fault), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      bus.rsp_ready = 1'b1;

`ifdef IMEM_PARITY_EN
      dut.u_array.mem[3][5] = ~dut.u_array.mem[3][5];
      issue(32'hC, 32'h0, 2'd3, 1'b1, 1'b1, w);
`else
      issue(32'hC, 32'h1234_5678, 2'd0, 1'b1, 1'b1, w);
`endif
      issue(32'h4, 32'h4139_03b3, 2'd0, 1'b1, 1'b1, w);
      bus.req_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
